// File: rtl/exe_stage_pkg.sv
// Shared types and encodings for the RV32IM execute stage: ALU/M-extension opcodes,
// divider FSM states and the packed inter-stage bus layouts.
package exe_stage_pkg;

   localparam int ID_EXE_BUS_W  = 164;
   localparam int EXE_MEM_BUS_W = 187;
   localparam int ES_FWD_BUS_W  = 39;

   typedef enum logic [4:0] {
      ALU_ADD   = 5'd0,
      ALU_SUB   = 5'd1,
      ALU_SLL   = 5'd2,
      ALU_SLT   = 5'd3,
      ALU_SLTU  = 5'd4,
      ALU_XOR   = 5'd5,
      ALU_SRL   = 5'd6,
      ALU_SRA   = 5'd7,
      ALU_OR    = 5'd8,
      ALU_AND   = 5'd9,
      ALU_COPY1 = 5'd10,
      ALU_COPY2 = 5'd11
   } alu_fn_e;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_e;

   localparam logic [2:0] WB_SEL_ALU = 3'd0;
   localparam logic [2:0] WB_SEL_MEM = 3'd1;
   localparam logic [2:0] WB_SEL_PC4 = 3'd2;
   localparam logic [2:0] WB_SEL_CSR = 3'd3;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   typedef struct packed {
      logic        md_en;
      logic [2:0]  md_op;
      logic [4:0]  alu_fn;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd;
      logic        rd_wen;
      logic        mem_we;
      logic        mem_re;
      logic [2:0]  wb_sel;
      logic [31:0] pc;
      logic [31:0] rs2_data;
      logic [3:0]  csr_cmd;
      logic [11:0] csr_addr;
   } id_exe_bus_t;

   typedef struct packed {
      logic [31:0] alu_result;
      logic [4:0]  rd;
      logic        rd_wen;
      logic        mem_we;
      logic        mem_re;
      logic [2:0]  wb_sel;
      logic [31:0] pc;
      logic [31:0] wb_mem_data;
      logic [3:0]  csr_cmd;
      logic [11:0] csr_addr;
      logic [31:0] op1_data;
      logic [31:0] mem_rd_data;
   } exe_mem_bus_t;

   function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/exe_stage_div_iter.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle on
// operand magnitudes, sign fix-up on the final iteration, RISC-V special cases short-cut.
module div_iter
   import exe_stage_pkg::*;
#(
   parameter int DIV_ITERS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        accept,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);
   // state    | meaning
   // DIV_IDLE | waiting for a divide in the stage; special cases go straight to DONE
   // DIV_BUSY | shift-subtract iterations, count 0..DIV_ITERS-1
   // DIV_DONE | result held until mem_stage takes the instruction

   localparam int CNT_W = $clog2(DIV_ITERS);

   div_state_e         state_q, state_d;
   logic [CNT_W-1:0]   count_q;
   logic [31:0]        quo_q, rem_q, dvs_q;
   logic               neg_q_q, neg_r_q;

   logic               div_zero, div_ovf, special, last_iter;
   logic               dividend_neg, divisor_neg;
   logic [31:0]        dd_mag, ds_mag;
   logic [32:0]        shifted, diff;
   logic               ge;
   logic [31:0]        rem_nx, quo_nx;

   assign div_zero     = (divisor == 32'd0);
   assign div_ovf      = is_signed & (dividend == 32'h8000_0000) & (divisor == 32'hFFFF_FFFF);
   assign special      = div_zero | div_ovf;
   assign dividend_neg = is_signed & dividend[31];
   assign divisor_neg  = is_signed & divisor[31];
   assign dd_mag       = neg_if(dividend_neg, dividend);
   assign ds_mag       = neg_if(divisor_neg, divisor);
   assign last_iter    = (count_q == CNT_W'(DIV_ITERS - 1));

   assign shifted = {rem_q, quo_q[31]};
   assign diff    = shifted - {1'b0, dvs_q};
   assign ge      = (shifted >= {1'b0, dvs_q});
   assign rem_nx  = ge ? diff[31:0] : shifted[31:0];
   assign quo_nx  = {quo_q[30:0], ge};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= DIV_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DIV_IDLE: if (start)     state_d = special ? DIV_DONE : DIV_BUSY;
         DIV_BUSY: if (last_iter) state_d = DIV_DONE;
         DIV_DONE: if (accept)    state_d = DIV_IDLE;
         default:                 state_d = DIV_IDLE;
      endcase
   end

   always_comb begin
      done = (state_q == DIV_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
      end else begin
         unique case (state_q)
            DIV_IDLE: begin
               if (start) begin
                  count_q <= '0;
                  if (div_zero) begin
                     quo_q <= 32'hFFFF_FFFF;
                     rem_q <= dividend;
                  end else if (div_ovf) begin
                     quo_q <= 32'h8000_0000;
                     rem_q <= 32'd0;
                  end else begin
                     quo_q   <= dd_mag;
                     rem_q   <= 32'd0;
                     dvs_q   <= ds_mag;
                     neg_q_q <= dividend_neg ^ divisor_neg;
                     neg_r_q <= dividend_neg;
                  end
               end
            end
            DIV_BUSY: begin
               count_q <= count_q + 1'b1;
               if (last_iter) begin
                  quo_q <= neg_if(neg_q_q, quo_nx);
                  rem_q <= neg_if(neg_r_q, rem_nx);
               end else begin
                  quo_q <= quo_nx;
                  rem_q <= rem_nx;
               end
            end
            default: ;
         endcase
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/exe_stage.sv
// RV32IM execute stage: latches the decode bus, runs the ALU and single-cycle multiplier,
// drives the data-memory read address and stalls on the iterative divider.
module exe_stage
   import exe_stage_pkg::*;
#(
   parameter int DIV_ITERS = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ID_EXE_BUS_W-1:0]  id_exe_bus_in,
   input  logic                     ds_to_es_valid,
   output logic                     es_allowin,
   input  logic                     ms_allowin,
   output logic                     es_to_ms_valid,
   output logic [EXE_MEM_BUS_W-1:0] exe_mem_bus_out,
   output logic [31:0]              dmem_raddr,
   input  logic [31:0]              dmem_rdata,
   output logic [ES_FWD_BUS_W-1:0]  es_fwd_bus
);

   id_exe_bus_t  bus_q;
   exe_mem_bus_t out_s;
   logic         es_valid, es_ready_go, is_mul, div_done;
   logic [31:0]  alu_out, md_result, alu_result, div_quo, div_rem;
   logic [4:0]   shamt;
   logic [32:0]  mul_a, mul_b;
   logic signed [63:0] prod;

   assign is_mul         = bus_q.md_en & ~bus_q.md_op[2];
   assign es_ready_go    = ~bus_q.md_en | div_done | is_mul;
   assign es_allowin     = ~es_valid | (es_ready_go & ms_allowin);
   assign es_to_ms_valid = es_valid & es_ready_go;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         es_valid <= 1'b0;
         bus_q    <= '0;
      end else begin
         if (es_allowin) es_valid <= ds_to_es_valid;
         if (es_allowin & ds_to_es_valid) bus_q <= id_exe_bus_in;
      end
   end

   assign shamt = bus_q.op2[4:0];

   always_comb begin
      alu_out = 32'd0;
      case (bus_q.alu_fn)
         ALU_ADD:   alu_out = bus_q.op1 + bus_q.op2;
         ALU_SUB:   alu_out = bus_q.op1 - bus_q.op2;
         ALU_SLL:   alu_out = bus_q.op1 << shamt;
         ALU_SLT:   alu_out = {31'd0, $signed(bus_q.op1) < $signed(bus_q.op2)};
         ALU_SLTU:  alu_out = {31'd0, bus_q.op1 < bus_q.op2};
         ALU_XOR:   alu_out = bus_q.op1 ^ bus_q.op2;
         ALU_SRL:   alu_out = bus_q.op1 >> shamt;
         ALU_SRA:   alu_out = $unsigned($signed(bus_q.op1) >>> shamt);
         ALU_OR:    alu_out = bus_q.op1 | bus_q.op2;
         ALU_AND:   alu_out = bus_q.op1 & bus_q.op2;
         ALU_COPY1: alu_out = bus_q.op1;
         ALU_COPY2: alu_out = bus_q.op2;
         default:   alu_out = 32'd0;
      endcase
   end

   // 33-bit operands let one signed multiplier cover MULH, MULHSU and MULHU.
   assign mul_a = {(bus_q.md_op != MD_MULHU) & bus_q.op1[31], bus_q.op1};
   assign mul_b = {((bus_q.md_op == MD_MUL) | (bus_q.md_op == MD_MULH)) & bus_q.op2[31], bus_q.op2};
   assign prod  = $signed(mul_a) * $signed(mul_b);

   div_iter #(.DIV_ITERS(DIV_ITERS)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (es_valid & bus_q.md_en & bus_q.md_op[2]),
      .is_signed (~bus_q.md_op[0]),
      .dividend  (bus_q.op1),
      .divisor   (bus_q.op2),
      .accept    (es_to_ms_valid & ms_allowin),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   always_comb begin
      md_result = 32'd0;
      case (bus_q.md_op)
         MD_MUL:                      md_result = prod[31:0];
         MD_MULH, MD_MULHSU, MD_MULHU: md_result = prod[63:32];
         default:                     md_result = bus_q.md_op[1] ? div_rem : div_quo;
      endcase
   end

   assign alu_result = bus_q.md_en ? md_result : alu_out;
   assign dmem_raddr = alu_out;

   always_comb begin
      out_s.alu_result  = alu_result;
      out_s.rd          = bus_q.rd;
      out_s.rd_wen      = bus_q.rd_wen;
      out_s.mem_we      = bus_q.mem_we;
      out_s.mem_re      = bus_q.mem_re;
      out_s.wb_sel      = bus_q.wb_sel;
      out_s.pc          = bus_q.pc;
      out_s.wb_mem_data = bus_q.rs2_data;
      out_s.csr_cmd     = bus_q.csr_cmd;
      out_s.csr_addr    = bus_q.csr_addr;
      out_s.op1_data    = bus_q.op1;
      out_s.mem_rd_data = dmem_rdata;
   end

   assign exe_mem_bus_out = out_s;
   assign es_fwd_bus      = {es_valid, bus_q.rd_wen, bus_q.rd, alu_result};

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage: ALU/MUL vectors, load path, divider
// latency and special cases, back-pressure, handshake ordering and mid-divide reset.
module tb_exe_stage;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [163:0] id_exe_bus_in;
   logic         ds_to_es_valid;
   logic         es_allowin;
   logic         ms_allowin;
   logic         es_to_ms_valid;
   logic [186:0] exe_mem_bus_out;
   logic [31:0]  dmem_raddr;
   logic [31:0]  dmem_rdata;
   logic [38:0]  es_fwd_bus;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign dmem_rdata = (dmem_raddr == 32'h0000_1004) ? 32'hDEAD_BEEF
                                                     : {dmem_raddr[15:0], dmem_raddr[31:16]};

   exe_stage dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_exe_bus_in   (id_exe_bus_in),
      .ds_to_es_valid  (ds_to_es_valid),
      .es_allowin      (es_allowin),
      .ms_allowin      (ms_allowin),
      .es_to_ms_valid  (es_to_ms_valid),
      .exe_mem_bus_out (exe_mem_bus_out),
      .dmem_raddr      (dmem_raddr),
      .dmem_rdata      (dmem_rdata),
      .es_fwd_bus      (es_fwd_bus)
   );

   wire [31:0] res_alu  = exe_mem_bus_out[186:155];
   wire [31:0] res_mrd  = exe_mem_bus_out[31:0];

   typedef struct packed {
      logic        md_en;
      logic [2:0]  op;
      logic [4:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic [31:0] addr;
   } vec_t;

   vec_t vecs [16] = '{
      '{1'b0, 3'd0, 5'd1,  32'd5,          32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFE},
      '{1'b0, 3'd0, 5'd2,  32'd1,          32'h0000_003F,  32'h8000_0000, 32'h8000_0000},
      '{1'b0, 3'd0, 5'd3,  32'hFFFF_FFFF,  32'd1,          32'd1,         32'd1},
      '{1'b0, 3'd0, 5'd4,  32'hFFFF_FFFF,  32'd1,          32'd0,         32'd0},
      '{1'b0, 3'd0, 5'd5,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0, 32'h0000_0FF0},
      '{1'b0, 3'd0, 5'd6,  32'h8000_0000,  32'd4,          32'h0800_0000, 32'h0800_0000},
      '{1'b0, 3'd0, 5'd7,  32'h8000_0000,  32'd4,          32'hF800_0000, 32'hF800_0000},
      '{1'b0, 3'd0, 5'd8,  32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF, 32'h0000_00FF},
      '{1'b0, 3'd0, 5'd9,  32'h0000_00F0,  32'h0000_003C,  32'h0000_0030, 32'h0000_0030},
      '{1'b0, 3'd0, 5'd10, 32'd1234,       32'd99,         32'd1234,      32'd1234},
      '{1'b0, 3'd0, 5'd11, 32'd1234,       32'd5678,       32'd5678,      32'd5678},
      '{1'b0, 3'd0, 5'd12, 32'd1234,       32'd5678,       32'd0,         32'd0},
      '{1'b1, 3'd0, 5'd0,  32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFD, 32'd2},
      '{1'b1, 3'd1, 5'd0,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'd0},
      '{1'b1, 3'd2, 5'd0,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{1'b1, 3'd3, 5'd0,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'hFFFF_FFFE}
   };

   task automatic check(input string tag, input logic [186:0] obs, input logic [186:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [163:0] mk(input logic md_en, input logic [2:0] md_op,
                                        input logic [4:0] fn, input logic [31:0] a,
                                        input logic [31:0] b, input logic mem_re);
      return {md_en, md_op, fn, a, b, 5'd3, 1'b1, 1'b0, mem_re, 3'd1,
              32'h0000_4000, 32'hCAFE_0001, 4'h5, 12'h300};
   endfunction

   // Presents one instruction; returns at the falling edge after it was latched.
   task automatic issue(input logic [163:0] bus);
      ds_to_es_valid = 1'b1;
      id_exe_bus_in  = bus;
      @(negedge clk);
      ds_to_es_valid = 1'b0;
      id_exe_bus_in  = '0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!es_to_ms_valid && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, sent, rcv;
      rst_n          = 1'b0;
      ds_to_es_valid = 1'b0;
      id_exe_bus_in  = '0;
      ms_allowin     = 1'b1;
      repeat (2) @(negedge clk);

      check("rst_valid",   {186'd0, es_to_ms_valid}, 187'd0);
      check("rst_allowin", {186'd0, es_allowin},     187'd1);
      check("rst_bus",     exe_mem_bus_out,          187'd0);
      check("rst_fwd",     {148'd0, es_fwd_bus},     187'd0);
      check("rst_raddr",   {155'd0, dmem_raddr},     187'd0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(mk(1'b0, 3'd0, 5'd0, 32'd5, 32'd7, 1'b0));
      check("add_valid", {186'd0, es_to_ms_valid}, 187'd1);
      check("add_bus", exe_mem_bus_out,
            {32'd12, 5'd3, 1'b1, 1'b0, 1'b0, 3'd1, 32'h0000_4000, 32'hCAFE_0001,
             4'h5, 12'h300, 32'd5, 32'h000C_0000});
      check("add_raddr", {155'd0, dmem_raddr}, 187'd12);
      check("add_fwd", {148'd0, es_fwd_bus}, {148'd0, 1'b1, 1'b1, 5'd3, 32'd12});

      issue(mk(1'b0, 3'd0, 5'd0, 32'h0000_1000, 32'd4, 1'b1));
      check("load_raddr", {155'd0, dmem_raddr}, {155'd0, 32'h0000_1004});
      check("load_data",  {155'd0, res_mrd},    {155'd0, 32'hDEAD_BEEF});

      for (int i = 0; i < 16; i++) begin
         issue(mk(vecs[i].md_en, vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b, 1'b0));
         check($sformatf("vec%0d_valid", i), {186'd0, es_to_ms_valid}, 187'd1);
         check($sformatf("vec%0d_result", i), {155'd0, res_alu}, {155'd0, vecs[i].exp});
         check($sformatf("vec%0d_raddr", i), {155'd0, dmem_raddr}, {155'd0, vecs[i].addr});
      end
      @(negedge clk);

      issue(mk(1'b1, 3'd4, 5'd0, 32'hFFFF_FFF9, 32'd2, 1'b0));
      check("div_stall_allowin", {186'd0, es_allowin}, 187'd0);
      wait_valid(n);
      check("div_latency", 187'(n), 187'd33);
      check("div_result", {155'd0, res_alu}, {155'd0, 32'hFFFF_FFFD});
      @(negedge clk);

      issue(mk(1'b1, 3'd6, 5'd0, 32'hFFFF_FFF9, 32'd2, 1'b0));
      wait_valid(n);
      check("rem_latency", 187'(n), 187'd33);
      check("rem_result", {155'd0, res_alu}, {155'd0, 32'hFFFF_FFFF});
      @(negedge clk);

      issue(mk(1'b1, 3'd5, 5'd0, 32'd1234, 32'd0, 1'b0));
      wait_valid(n);
      check("divu0_latency", 187'(n), 187'd1);
      check("divu0_result", {155'd0, res_alu}, {155'd0, 32'hFFFF_FFFF});
      @(negedge clk);

      issue(mk(1'b1, 3'd4, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0));
      wait_valid(n);
      check("ovf_div_latency", 187'(n), 187'd1);
      check("ovf_div_result", {155'd0, res_alu}, {155'd0, 32'h8000_0000});
      @(negedge clk);

      issue(mk(1'b1, 3'd6, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0));
      wait_valid(n);
      check("ovf_rem_result", {155'd0, res_alu}, 187'd0);
      @(negedge clk);

      ms_allowin = 1'b0;
      issue(mk(1'b1, 3'd4, 5'd0, 32'd100, 32'd7, 1'b0));
      wait_valid(n);
      check("hold_latency", 187'(n), 187'd33);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("hold%0d_valid", i), {186'd0, es_to_ms_valid}, 187'd1);
         check($sformatf("hold%0d_result", i), {155'd0, res_alu}, 187'd14);
      end
      ms_allowin = 1'b1;
      @(negedge clk);
      check("hold_released", {186'd0, es_to_ms_valid}, 187'd0);

      sent = 0;
      rcv  = 0;
      for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
         ms_allowin     = (cyc % 3 != 1);
         ds_to_es_valid = (sent < 8);
         id_exe_bus_in  = mk(1'b0, 3'd0, 5'd0, 32'(sent), 32'd1000, 1'b0);
         #1;
         if (es_to_ms_valid && ms_allowin) begin
            check($sformatf("b2b%0d", rcv), {155'd0, res_alu}, 187'(1000 + rcv));
            rcv++;
         end
         if (es_allowin && ds_to_es_valid) sent++;
         @(negedge clk);
      end
      ds_to_es_valid = 1'b0;
      ms_allowin     = 1'b1;
      check("b2b_count", 187'(rcv), 187'd8);
      @(negedge clk);
      check("b2b_no_dup", {186'd0, es_to_ms_valid}, 187'd0);

      issue(mk(1'b1, 3'd5, 5'd0, 32'd1000, 32'd3, 1'b0));
      repeat (11) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_valid",   {186'd0, es_to_ms_valid}, 187'd0);
      check("midrst_allowin", {186'd0, es_allowin},     187'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      issue(mk(1'b1, 3'd5, 5'd0, 32'd100, 32'd7, 1'b0));
      wait_valid(n);
      check("post_rst_latency", 187'(n), 187'd33);
      check("post_rst_result", {155'd0, res_alu}, 187'd14);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
